// File: rtl/line_reg_queue.sv
// First-word-fall-through queue of line descriptors {StartX, EndX, StartY, EndY, Color}.
// The head entry is visible on Q* with zero read latency; Q* reads as zero while empty.
module line_reg_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 11
) (
    output logic [CW-1:0] QStartX,
    output logic [CW-1:0] QEndX,
    output logic [CW-1:0] QStartY,
    output logic [CW-1:0] QEndY,
    output logic [2:0]    QColor,
    output logic          full,
    output logic          empty,
    input  logic [CW-1:0] DStartX,
    input  logic [CW-1:0] DEndX,
    input  logic [CW-1:0] DStartY,
    input  logic [CW-1:0] DEndY,
    input  logic [2:0]    DColor,
    input  logic          read,
    input  logic          write,
    input  logic          clk,
    input  logic          rst_b
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned EW   = 4 * CW + 3;

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            push_c, pop_c;
    logic [EW-1:0]   head_c;

    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full queue is only legal when the head leaves on the same edge.
    assign pop_c  = read & ~empty;
    assign push_c = write & (~full | read);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is left uncleared by reset; emptiness is tracked by the counter alone.
    always_ff @(posedge clk) begin
        if (!rst_b && push_c) begin
            mem_q[wr_ptr_q] <= {DStartX, DEndX, DStartY, DEndY, DColor};
        end
    end

    assign head_c = empty ? '0 : mem_q[rd_ptr_q];
    assign {QStartX, QEndX, QStartY, QEndY, QColor} = head_c;

endmodule

// File: tb/tb_line_reg_queue.sv
// Randomized and directed bench for line_reg_queue against a queue-based reference model.
module tb_line_reg_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 11;
    localparam int unsigned EW    = 4 * CW + 3;

    typedef logic [EW-1:0] entry_t;

    logic          clk;
    logic          rst_b;
    logic          read, write;
    logic [CW-1:0] DStartX, DEndX, DStartY, DEndY;
    logic [2:0]    DColor;
    logic [CW-1:0] QStartX, QEndX, QStartY, QEndY;
    logic [2:0]    QColor;
    logic          full, empty;

    int     checks;
    int     failures;
    bit     armed;
    entry_t mq[$];

    line_reg_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .QStartX(QStartX), .QEndX(QEndX), .QStartY(QStartY), .QEndY(QEndY),
        .QColor(QColor), .full(full), .empty(empty),
        .DStartX(DStartX), .DEndX(DEndX), .DStartY(DStartY), .DEndY(DEndY),
        .DColor(DColor), .read(read), .write(write), .clk(clk), .rst_b(rst_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic entry_t mk(input int sx, input int ex, input int sy, input int ey, input int c);
        return {CW'(sx), CW'(ex), CW'(sy), CW'(ey), 3'(c)};
    endfunction

    function automatic entry_t rnd_entry();
        return {CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), 3'($urandom)};
    endfunction

    // One clock: drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
    task automatic do_cycle(input logic r, input logic w, input logic rst, input entry_t d);
        bit pop_ok, push_ok;
        read  = r;
        write = w;
        rst_b = rst;
        {DStartX, DEndX, DStartY, DEndY, DColor} = d;
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            pop_ok  = r && (mq.size() > 0);
            push_ok = w && ((mq.size() < DEPTH) || pop_ok);
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
        @(negedge clk);
        if (armed) begin
            check("empty", 64'(empty), 64'(mq.size() == 0));
            check("full",  64'(full),  64'(mq.size() == DEPTH));
            check("head",  64'({QStartX, QEndX, QStartY, QEndY, QColor}),
                  64'((mq.size() > 0) ? mq[0] : entry_t'(0)));
        end
    endtask

    initial begin
        int     writes_done, burst_left, cyc;
        bit     reset_done;
        logic   r, w, rs;
        entry_t d;

        checks   = 0;
        failures = 0;
        armed    = 1'b0;
        read     = 1'b0;
        write    = 1'b0;
        rst_b    = 1'b1;
        {DStartX, DEndX, DStartY, DEndY, DColor} = '0;
        @(negedge clk);

        // Reset with a simultaneous write to show reset priority, then idle.
        do_cycle(1'b0, 1'b1, 1'b1, rnd_entry());
        armed = 1'b1;
        do_cycle(1'b1, 1'b1, 1'b1, rnd_entry());
        do_cycle(1'b0, 1'b0, 1'b0, rnd_entry());
        check("idle_empty", 64'(empty), 64'd1);
        check("idle_full",  64'(full),  64'd0);
        check("idle_qsx",   64'(QStartX), 64'd0);

        // Single entry round trip with fixed values.
        do_cycle(1'b0, 1'b1, 1'b0, mk('h010, 'h020, 'h030, 'h040, 5));
        check("one_sx",    64'(QStartX), 64'h010);
        check("one_ex",    64'(QEndX),   64'h020);
        check("one_sy",    64'(QStartY), 64'h030);
        check("one_ey",    64'(QEndY),   64'h040);
        check("one_col",   64'(QColor),  64'd5);
        check("one_empty", 64'(empty),   64'd0);
        do_cycle(1'b1, 1'b0, 1'b0, rnd_entry());
        check("one_pop_empty", 64'(empty), 64'd1);
        check("one_pop_q",     64'({QStartX, QEndX, QStartY, QEndY, QColor}), 64'd0);

        // Fill to capacity, drop the overflow write, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            d = rnd_entry();
            d[EW-1 -: CW] = CW'(i);
            do_cycle(1'b0, 1'b1, 1'b0, d);
        end
        check("fill_full", 64'(full), 64'd1);
        d = rnd_entry();
        d[EW-1 -: CW] = CW'(99);
        do_cycle(1'b0, 1'b1, 1'b0, d);
        check("ovf_full", 64'(full),    64'd1);
        check("ovf_head", 64'(QStartX), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 64'(QStartX), 64'(i));
            do_cycle(1'b1, 1'b0, 1'b0, rnd_entry());
        end
        check("drain_empty", 64'(empty), 64'd1);

        // Simultaneous read and write while full.
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b1, 1'b0, rnd_entry());
        d = rnd_entry();
        d[EW-1 -: CW] = CW'(77);
        do_cycle(1'b1, 1'b1, 1'b0, d);
        check("rw_full_full", 64'(full), 64'd1);
        for (int i = 0; i < DEPTH - 1; i++) do_cycle(1'b1, 1'b0, 1'b0, rnd_entry());
        check("rw_full_last", 64'(QStartX), 64'd77);
        do_cycle(1'b1, 1'b0, 1'b0, rnd_entry());
        check("rw_full_done", 64'(empty), 64'd1);

        // Simultaneous read and write while empty: only the push happens.
        d = rnd_entry();
        do_cycle(1'b1, 1'b1, 1'b0, d);
        check("rw_empty_notempty", 64'(empty), 64'd0);
        check("rw_empty_head", 64'({QStartX, QEndX, QStartY, QEndY, QColor}), 64'(d));
        do_cycle(1'b1, 1'b0, 1'b0, rnd_entry());

        // Bursty writes, one read per 16 cycles, one reset while 5 entries are held.
        writes_done = 0;
        burst_left  = 0;
        reset_done  = 1'b0;
        cyc         = 0;
        while ((writes_done < 40 || mq.size() > 0) && cyc < 2000) begin
            r = ((cyc % 16) == 15);
            if (burst_left == 0 && $urandom_range(0, 3) == 0) burst_left = $urandom_range(2, 6);
            w = (burst_left > 0) && (writes_done < 40);
            if (w) begin
                burst_left--;
                writes_done++;
            end
            rs = !reset_done && (mq.size() == 5);
            if (rs) reset_done = 1'b1;
            do_cycle(r, w, rs, rnd_entry());
            cyc++;
        end
        check("burst_reset_seen", 64'(reset_done), 64'd1);
        check("burst_in_budget",  64'(cyc < 2000), 64'd1);
        check("burst_end_empty",  64'(empty), 64'd1);

        // Free-running random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) == 0), rnd_entry());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
